// File: rtl/div_unit_pkg.sv
// Shared types for the iterative divide unit.
package div_unit_pkg;

   // Operation encoding presented by the execute stage.
   typedef enum logic [1:0] {
      SS_DIV = 2'b00,
      UU_DIV = 2'b01,
      SS_REM = 2'b10,
      UU_REM = 2'b11
   } div_type_t;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring 32-bit divide/remainder unit (DIV/DIVU/REM/REMU).
module div_unit
   import div_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [4:0]  req_rd,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic [4:0]  resp_rd,
   output logic        busy
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 5;
   localparam int unsigned TAG_W = 5;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN:0]    rem_q, rem_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic             is_rem_q, is_rem_d;
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic [TAG_W-1:0] rd_q, rd_d;

   div_type_t        op;
   logic             op_signed, op_rem;
   logic             a_neg, b_neg;
   logic [XLEN-1:0]  a_mag, b_mag;
   logic             div_zero, ovf;
   logic [XLEN+1:0]  shifted, diff;
   logic             diff_neg;
   logic [XLEN:0]    rem_n;
   logic [XLEN-1:0]  quo_n, q_fix, r_fix;

   // Request decode: signedness, operand magnitudes and special cases.
   assign op        = div_type_t'(req_op);
   assign op_signed = (op == SS_DIV) || (op == SS_REM);
   assign op_rem    = (op == SS_REM) || (op == UU_REM);
   assign a_neg     = op_signed & req_a[XLEN-1];
   assign b_neg     = op_signed & req_b[XLEN-1];
   assign a_mag     = a_neg ? XLEN'(-req_a) : req_a;
   assign b_mag     = b_neg ? XLEN'(-req_b) : req_b;
   assign div_zero  = (req_b == '0);
   assign ovf       = op_signed && (req_a == INT_MIN) && (req_b == '1);

   // One restoring step: shift in next dividend bit, trial-subtract divisor.
   assign shifted  = {rem_q, quo_q[XLEN-1]};
   assign diff     = shifted - {2'b00, dvs_q};
   assign diff_neg = diff[XLEN+1];
   assign rem_n    = diff_neg ? shifted[XLEN:0] : diff[XLEN:0];
   assign quo_n    = {quo_q[XLEN-2:0], ~diff_neg};

   // Sign correction applied on the final iteration.
   assign q_fix = neg_q_q ? XLEN'(-quo_n) : quo_n;
   assign r_fix = neg_r_q ? XLEN'(-rem_n[XLEN-1:0]) : rem_n[XLEN-1:0];

   // Next-state and datapath update; flush overrides everything.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      is_rem_d = is_rem_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      result_d = result_q;
      rd_d     = rd_q;

      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  rd_d     = req_rd;
                  is_rem_d = op_rem;
                  neg_q_d  = a_neg ^ b_neg;
                  neg_r_d  = a_neg;
                  dvs_d    = b_mag;
                  rem_d    = '0;
                  quo_d    = a_mag;
                  cnt_d    = CNT_W'(XLEN - 1);
                  if (div_zero) begin
                     result_d = op_rem ? req_a : '1;
                     state_d  = DONE;
                  end else if (ovf) begin
                     result_d = op_rem ? '0 : INT_MIN;
                     state_d  = DONE;
                  end else begin
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               rem_d = rem_n;
               quo_d = quo_n;
               if (cnt_q == '0) begin
                  result_d = is_rem_q ? r_fix : q_fix;
                  state_d  = DONE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         is_rem_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         is_rem_q <= is_rem_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         result_q <= result_d;
         rd_q     <= rd_d;
      end
   end

   assign req_ready   = (state_q == IDLE);
   assign resp_valid  = (state_q == DONE);
   assign busy        = (state_q != IDLE);
   assign resp_result = result_q;
   assign resp_rd     = rd_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;

   localparam logic [1:0] OP_SS_DIV = 2'b00;
   localparam logic [1:0] OP_UU_DIV = 2'b01;
   localparam logic [1:0] OP_SS_REM = 2'b10;
   localparam logic [1:0] OP_UU_REM = 2'b11;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_result;
   logic [4:0]  resp_rd;
   logic        busy;

   int errors = 0;
   int checks = 0;

   div_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_rd      (req_rd),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_rd     (resp_rd),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one op; k = rising edges after the accept edge before resp_valid is seen
   // (0 for special cases, 32 for normal ops).
   task automatic issue_and_wait(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 output int k);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_rd    = rd;
      @(negedge clk);
      req_valid = 1'b0;
      k = 0;
      while (!resp_valid && k < 64) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_k);
      int k;
      resp_ready = 1'b1;
      issue_and_wait(op, a, b, rd, k);
      checks++;
      if (resp_valid !== 1'b1 || k !== exp_k) begin
         errors++;
         $display("FAIL %s latency: valid=%b edges=%0d required valid=1 edges=%0d",
                  name, resp_valid, k, exp_k);
      end
      checks++;
      if (resp_result !== exp) begin
         errors++;
         $display("FAIL %s result: got %h required %h", name, resp_result, exp);
      end
      checks++;
      if (resp_rd !== rd) begin
         errors++;
         $display("FAIL %s rd: got %0d required %0d", name, resp_rd, rd);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s release: valid=%b ready=%b required valid=0 ready=1",
                  name, resp_valid, req_ready);
      end
   endtask

   task automatic check_idle_outputs(input string name, input logic [31:0] exp_res,
                                     input logic [4:0] exp_rd);
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 ||
          resp_result !== exp_res || resp_rd !== exp_rd) begin
         errors++;
         $display("FAIL %s: ready=%b busy=%b valid=%b result=%h rd=%0d required 1 0 0 %h %0d",
                  name, req_ready, busy, resp_valid, resp_result, resp_rd, exp_res, exp_rd);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      req_valid = 1'b0;
      req_op = 2'b00;
      req_a = '0;
      req_b = '0;
      req_rd = '0;
      resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_in", 32'h0, 5'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("reset_out", 32'h0, 5'd0);
   endtask

   task automatic test_unsigned();
      run_op("uu_div_100_7", OP_UU_DIV, 32'd100, 32'd7, 5'd5, 32'd14, 32);
      run_op("uu_rem_100_7", OP_UU_REM, 32'd100, 32'd7, 5'd5, 32'd2, 32);
      run_op("uu_rem_max_16", OP_UU_REM, 32'hFFFF_FFFF, 32'h10, 5'd31, 32'hF, 32);
   endtask

   task automatic test_signed();
      run_op("ss_div_m7_2", OP_SS_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 32);
      run_op("ss_rem_m7_2", OP_SS_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 32);
      run_op("uu_div_m7_2", OP_UU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'h7FFF_FFFC, 32);
      run_op("ss_rem_7_m2", OP_SS_REM, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1, 32);
      run_op("ss_div_m100_m7", OP_SS_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd6, 32'd14, 32);
   endtask

   task automatic test_special();
      run_op("uu_div_by0", OP_UU_DIV, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 0);
      run_op("uu_rem_by0", OP_UU_REM, 32'd5, 32'd0, 5'd8, 32'd5, 0);
      run_op("ss_div_by0", OP_SS_DIV, 32'hFFFF_FFF9, 32'd0, 5'd9, 32'hFFFF_FFFF, 0);
      run_op("ss_rem_min_by0", OP_SS_REM, 32'h8000_0000, 32'd0, 5'd10, 32'h8000_0000, 0);
      run_op("ss_div_ovf", OP_SS_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
      run_op("ss_rem_ovf", OP_SS_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 0);
      run_op("uu_div_min_max", OP_UU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0, 32);
   endtask

   task automatic test_backpressure();
      int k;
      resp_ready = 1'b0;
      issue_and_wait(OP_UU_DIV, 32'd100, 32'd7, 5'd9, k);
      checks++;
      if (resp_valid !== 1'b1 || k !== 32) begin
         errors++;
         $display("FAIL bp_latency: valid=%b edges=%0d required valid=1 edges=32", resp_valid, k);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_result !== 32'd14 ||
             resp_rd !== 5'd9) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: valid=%b ready=%b result=%h rd=%0d required 1 0 0000000e 9",
                     i, resp_valid, req_ready, resp_result, resp_rd);
         end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      checks++;
      if (resp_valid !== 1'b1 || resp_result !== 32'd14) begin
         errors++;
         $display("FAIL bp_cycle6: valid=%b result=%h required 1 0000000e", resp_valid, resp_result);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: ready=%b valid=%b required 1 0", req_ready, resp_valid);
      end
   endtask

   task automatic test_flush();
      int seen;
      resp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b1;
      req_op = OP_UU_DIV;
      req_a = 32'd1000;
      req_b = 32'd3;
      req_rd = 5'd14;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_precalc: busy=%b valid=%b required 1 0", busy, resp_valid);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle: busy=%b ready=%b valid=%b required 0 1 0",
                  busy, req_ready, resp_valid);
      end
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL flush_no_resp: valid cycles=%0d required 0", seen);
      end
      run_op("after_flush_1000_3", OP_UU_DIV, 32'd1000, 32'd3, 5'd15, 32'd333, 32);

      // Flush together with a request in IDLE must not accept.
      @(negedge clk);
      req_valid = 1'b1;
      flush = 1'b1;
      req_op = OP_UU_DIV;
      req_a = 32'd5;
      req_b = 32'd0;
      @(negedge clk);
      req_valid = 1'b0;
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_blocks_accept: busy=%b valid=%b ready=%b required 0 0 1",
                  busy, resp_valid, req_ready);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL flush_blocks_accept_late: valid=%b busy=%b required 0 0", resp_valid, busy);
      end
   endtask

   task automatic test_reset_mid_op();
      int seen;
      resp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b1;
      req_op = OP_SS_DIV;
      req_a = 32'd100;
      req_b = 32'd7;
      req_rd = 5'd21;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("reset_mid_op", 32'h0, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL reset_no_resp: valid cycles=%0d required 0", seen);
      end
      run_op("ss_div_min_2", OP_SS_DIV, 32'h8000_0000, 32'd2, 5'd22, 32'hC000_0000, 32);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_special();
      test_backpressure();
      test_flush();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
